// File: rtl/servo_sweep_ctrl_if.sv
// Control/status bundle between a sweep sequencer (master) and servo_sweep_ctrl (slave).
// Pulse inputs are single-cycle; duty feeds the 50 Hz PWM generator downstream.
interface servo_sweep_ctrl_if;
   logic       start;
   logic       stop;
   logic       dir_toggle;
   logic       set_min;
   logic       set_max;
   logic [6:0] limit_val;
   logic [6:0] duty;
   logic       busy;
   logic       at_limit;

   modport master (
      output start, stop, dir_toggle, set_min, set_max, limit_val,
      input  duty, busy, at_limit
   );

   modport slave (
      input  start, stop, dir_toggle, set_min, set_max, limit_val,
      output duty, busy, at_limit
   );
endinterface

// File: rtl/servo_sweep_ctrl.sv
// Servo duty sweeper: ramps duty between programmable limits one step per prescaler
// tick, dwelling at each end point, with stop/resume, direction reversal and limit loading.
module servo_sweep_ctrl #(
   parameter int SYS_CLK_HZ   = 100_000_000,
   parameter int STEP_MS      = 10,
   parameter int DWELL_STEPS  = 50,
   parameter int DUTY_MIN_RST = 15,
   parameter int DUTY_MAX_RST = 75
) (
   input  logic               clk,
   input  logic               reset_p,
   servo_sweep_ctrl_if.slave  bus
);

   localparam int PRESCALE = SYS_CLK_HZ / 1000 * STEP_MS;
   localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW       = (DWELL_STEPS > 0) ? $clog2(DWELL_STEPS + 1) : 1;

   localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] DW_LAST   = DW'(DWELL_STEPS);
   localparam logic [6:0]    MIN_RST   = 7'(DUTY_MIN_RST);
   localparam logic [6:0]    MAX_RST   = 7'(DUTY_MAX_RST);
   localparam logic [6:0]    DUTY_CEIL = 7'd100;

   typedef enum logic [2:0] {IDLE, UP, DWELL_TOP, DOWN, DWELL_BOT} state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic [DW-1:0] dwell, dwell_n;
   logic [6:0]    duty_q, duty_n, duty_c;
   logic [6:0]    duty_min, duty_max, dmin_n, dmax_n;
   logic          last_up, last_up_n;
   logic          busy_q, at_limit_q;
   logic          step_tick;

   assign step_tick = (state != IDLE) && (presc == PS_LAST);

   // Duty pulled into the current limits; equals duty_q except the cycle after a limit change.
   always_comb begin
      duty_c = duty_q;
      if (duty_q < duty_min)      duty_c = duty_min;
      else if (duty_q > duty_max) duty_c = duty_max;
   end

   always_comb begin
      state_n   = state;
      presc_n   = presc;
      dwell_n   = dwell;
      duty_n    = duty_c;
      dmin_n    = duty_min;
      dmax_n    = duty_max;
      last_up_n = last_up;

      if (state != IDLE)
         presc_n = (presc == PS_LAST) ? '0 : presc + 1'b1;

      // Strict priority chain: only the highest pending event acts this cycle.
      if (bus.stop) begin
         state_n = IDLE;
         presc_n = '0;
         case (state)
            UP, DWELL_BOT:   last_up_n = 1'b1;
            DOWN, DWELL_TOP: last_up_n = 1'b0;
            default: ;
         endcase
      end else if (bus.start) begin
         presc_n = '0;
         if (state == IDLE)
            state_n = last_up ? UP : DOWN;
      end else if (bus.dir_toggle) begin
         case (state)
            UP, DWELL_TOP:  state_n = DOWN;
            DOWN, DWELL_BOT: state_n = UP;
            default:         last_up_n = ~last_up;
         endcase
      end else if (bus.set_min) begin
         if (bus.limit_val != 7'd0 && bus.limit_val < duty_max)
            dmin_n = bus.limit_val;
      end else if (bus.set_max) begin
         if (bus.limit_val > duty_min && bus.limit_val <= DUTY_CEIL)
            dmax_n = bus.limit_val;
      end else if (step_tick) begin
         case (state)
            UP: begin
               if (duty_c < duty_max) duty_n = duty_c + 7'd1;
               else begin
                  state_n = DWELL_TOP;
                  dwell_n = '0;
               end
            end
            DOWN: begin
               if (duty_c > duty_min) duty_n = duty_c - 7'd1;
               else begin
                  state_n = DWELL_BOT;
                  dwell_n = '0;
               end
            end
            // Exit tick leaves duty alone; DWELL_STEPS=0 exits on the first tick.
            DWELL_TOP: begin
               if (dwell == DW_LAST) state_n = DOWN;
               else                  dwell_n = dwell + 1'b1;
            end
            DWELL_BOT: begin
               if (dwell == DW_LAST) state_n = UP;
               else                  dwell_n = dwell + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state      <= IDLE;
         presc      <= '0;
         dwell      <= '0;
         duty_q     <= MIN_RST;
         duty_min   <= MIN_RST;
         duty_max   <= MAX_RST;
         last_up    <= 1'b1;
         busy_q     <= 1'b0;
         at_limit_q <= 1'b0;
      end else begin
         state      <= state_n;
         presc      <= presc_n;
         dwell      <= dwell_n;
         duty_q     <= duty_n;
         duty_min   <= dmin_n;
         duty_max   <= dmax_n;
         last_up    <= last_up_n;
         busy_q     <= (state_n != IDLE);
         at_limit_q <= (state_n == DWELL_TOP) || (state_n == DWELL_BOT);
      end
   end

   assign bus.duty     = duty_q;
   assign bus.busy     = busy_q;
   assign bus.at_limit = at_limit_q;

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Directed bench for servo_sweep_ctrl with a 10-cycle step tick and two-step dwell.
// Cycle offsets in comments count posedges from the named reference pulse.
module tb_servo_sweep_ctrl;

   logic clk = 1'b0;
   logic reset_p;
   int   checks   = 0;
   int   failures = 0;

   servo_sweep_ctrl_if bus ();

   servo_sweep_ctrl #(
      .SYS_CLK_HZ  (10000),
      .STEP_MS     (1),
      .DWELL_STEPS (2),
      .DUTY_MIN_RST(15),
      .DUTY_MAX_RST(75)
   ) dut (
      .clk    (clk),
      .reset_p(reset_p),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input int d, input bit b, input bit a);
      chk({tag, ".duty"},     32'(bus.duty),     32'(d));
      chk({tag, ".busy"},     32'(bus.busy),     32'(b));
      chk({tag, ".at_limit"}, 32'(bus.at_limit), 32'(a));
   endtask

   task automatic pulse(input bit st, input bit sp, input bit dt,
                        input bit smn, input bit smx, input logic [6:0] lv);
      bus.start = st; bus.stop = sp; bus.dir_toggle = dt;
      bus.set_min = smn; bus.set_max = smx; bus.limit_val = lv;
      tick(1);
      bus.start = 0; bus.stop = 0; bus.dir_toggle = 0;
      bus.set_min = 0; bus.set_max = 0; bus.limit_val = '0;
   endtask

   initial begin
      bus.start = 0; bus.stop = 0; bus.dir_toggle = 0;
      bus.set_min = 0; bus.set_max = 0; bus.limit_val = '0;
      reset_p = 1'b1;
      #2;
      outs("reset", 15, 0, 0);
      tick(2);
      reset_p = 1'b0;
      tick(1);

      // Full up-sweep from reset limits (E0 = start edge)
      pulse(1, 0, 0, 0, 0, 7'd0);
      outs("start", 15, 1, 0);
      tick(9);   chk("e0_9.duty", 32'(bus.duty), 15);
      tick(1);   chk("e0_10.duty", 32'(bus.duty), 16);
      tick(589); chk("e0_599.duty", 32'(bus.duty), 74);
      tick(1);   outs("e0_600", 75, 1, 0);
      tick(10);  outs("dwell_top_in", 75, 1, 1);
      tick(29);  chk("dwell_top_last.at_limit", 32'(bus.at_limit), 1);
      tick(1);   outs("dwell_top_out", 75, 1, 0);
      tick(10);  chk("down_first.duty", 32'(bus.duty), 74);
      tick(599); outs("e0_1249", 15, 1, 0);
      tick(1);   outs("dwell_bot_in", 15, 1, 1);

      // dir_toggle inside DWELL_BOT leaves the dwell immediately
      tick(3);
      pulse(0, 0, 1, 0, 0, 7'd0);
      outs("tog_dwell_bot", 15, 1, 0);
      tick(5);   chk("e0_1259.duty", 32'(bus.duty), 15);
      tick(1);   chk("e0_1260.duty", 32'(bus.duty), 16);
      tick(140); chk("e0_1400.duty", 32'(bus.duty), 30);

      // Reverse at 30, then reverse back
      tick(2);
      pulse(0, 0, 1, 0, 0, 7'd0);
      chk("tog_up.duty", 32'(bus.duty), 30);
      tick(6);   chk("tog_up_wait.duty", 32'(bus.duty), 30);
      tick(1);   chk("tog_up_step.duty", 32'(bus.duty), 29);
      tick(2);
      pulse(0, 0, 1, 0, 0, 7'd0);
      tick(7);   chk("tog_down_step.duty", 32'(bus.duty), 30);
      tick(100); chk("e0_1520.duty", 32'(bus.duty), 40);

      // Stop at 40 while UP, then resume (S = resume edge)
      tick(2);
      pulse(0, 1, 0, 0, 0, 7'd0);
      outs("stop40", 40, 0, 0);
      tick(30);  outs("idle_hold", 40, 0, 0);
      pulse(1, 0, 0, 0, 0, 7'd0);
      outs("resume", 40, 1, 0);
      tick(9);   chk("s9.duty", 32'(bus.duty), 40);
      tick(1);   chk("s10.duty", 32'(bus.duty), 41);
      tick(290); chk("s300.duty", 32'(bus.duty), 70);

      // Lower the top limit below duty: clamp lands one cycle later
      tick(2);
      pulse(0, 0, 0, 0, 1, 7'd50);
      chk("setmax50_same.duty", 32'(bus.duty), 70);
      tick(1);   chk("setmax50_clamp.duty", 32'(bus.duty), 50);
      tick(6);   outs("clamp_dwell", 50, 1, 1);
      tick(1);
      pulse(0, 0, 0, 0, 1, 7'd10);
      pulse(0, 0, 0, 1, 0, 7'd0);
      tick(1);   outs("rejects", 50, 1, 1);
      tick(26);  outs("s340", 50, 1, 0);
      tick(10);  chk("s350.duty", 32'(bus.duty), 49);
      tick(20);  chk("s370.duty", 32'(bus.duty), 47);

      // set_min coinciding with a step tick wins and the step is dropped
      tick(9);
      pulse(0, 0, 0, 1, 0, 7'd45);
      chk("setmin_tick.duty", 32'(bus.duty), 47);
      tick(9);   chk("s389.duty", 32'(bus.duty), 47);
      tick(1);   chk("s390.duty", 32'(bus.duty), 46);
      tick(10);  chk("s400.duty", 32'(bus.duty), 45);
      tick(10);  outs("new_min_dwell", 45, 1, 1);

      // stop and start together -> stop wins
      tick(1);
      pulse(1, 1, 0, 0, 0, 7'd0);
      outs("stop_start", 45, 0, 0);
      tick(10);  chk("stop_start_hold.busy", 32'(bus.busy), 0);

      // Reprogram limits in IDLE, flip direction, start downward (T = start edge)
      pulse(0, 0, 0, 1, 0, 7'd20);
      pulse(0, 0, 0, 0, 1, 7'd75);
      pulse(0, 0, 1, 0, 0, 7'd0);
      pulse(1, 0, 0, 0, 0, 7'd0);
      outs("start_down", 45, 1, 0);
      tick(10);  chk("t10.duty", 32'(bus.duty), 44);
      tick(40);  chk("t50.duty", 32'(bus.duty), 40);

      // start while running restarts the prescaler
      tick(4);
      pulse(1, 0, 0, 0, 0, 7'd0);
      tick(5);   outs("restart_no_tick", 40, 1, 0);
      tick(5);   chk("restart_tick.duty", 32'(bus.duty), 39);
      tick(60);  chk("t125.duty", 32'(bus.duty), 33);

      // Reset mid-DOWN takes effect between clock edges
      tick(3);
      reset_p = 1'b1;
      #2;
      outs("async_reset", 15, 0, 0);
      tick(1);
      reset_p = 1'b0;
      tick(30);
      outs("post_reset_idle", 15, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
